// File: rtl/cpu_pkg.sv
// Shared types for the memory stage: load/store funct3 encodings, stage FSM states, bus geometry.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int ADDR_WIDTH              = 32;
   localparam int DATA_WIDTH              = 32;
   localparam int NUM_REGISTERS           = 32;
   localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
   localparam int NUM_LANES               = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'd0,
      SH = 3'd1,
      SW = 3'd2
   } store_funct3_t;

   typedef enum logic [1:0] {
      EMPTY,
      REQUEST,
      RESPONSE,
      DONE
   } memory_state_t;

   // True when funct3 names a real load (is_load=1) or store (is_load=0) width.
   function automatic logic funct3_legal(input logic is_load, input logic [2:0] funct3);
      if (is_load) begin
         return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                (funct3 == LBU) || (funct3 == LHU);
      end
      return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a bus response word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
   import cpu_pkg::*;
(
   input  logic [2:0]            funct3,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] word,
   output logic [DATA_WIDTH-1:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the lane named by the low address bits, then extend by access width.
   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         LB:      value = {{24{byte_sel[7]}}, byte_sel};
         LBU:     value = {24'h0, byte_sel};
         LH:      value = {{16{half_sel[15]}}, half_sel};
         LHU:     value = {16'h0, half_sel};
         default: value = word;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results through, performs loads/stores over a req/resp data port.
// Latency: 1 cycle for non-memory ops; >=3 cycles accept->done_next for memory ops.
// Backpressure: stall_prev held while occupied unless DONE drains this cycle; optional MEMORY_STAGE_MISALIGN_TRAP_EN traps misaligned H/W.
module memory_stage
   import cpu_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst,
   output logic                               stall_prev,
   input  logic                               prev_done,
   input  logic                               next_stall,
   output logic                               done_next,
   output logic [REGISTER_INDEXING_WIDTH-1:0] instruction_writeback_register,
   output logic                               instruction_writeback_enabled,
   input  logic [ADDR_WIDTH-1:0]              program_count_in,
   input  logic                               load_in,
   input  logic                               store_in,
   input  logic [2:0]                         funct_3_in,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
   input  logic                               writeback_enabled_in,
   input  logic [DATA_WIDTH-1:0]              result_data_in,
   input  logic                               result_data_valid_in,
   input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
   input  logic                               memory_store_data_valid_in,
   output logic                               mem_request_valid,
   input  logic                               mem_request_ready,
   output logic [ADDR_WIDTH-1:0]              mem_address,
   output logic                               mem_write,
   output logic [NUM_LANES-1:0]               mem_byte_enable,
   output logic [DATA_WIDTH-1:0]              mem_write_data,
   input  logic                               mem_response_valid,
   input  logic [DATA_WIDTH-1:0]              mem_response_data,
   output logic [ADDR_WIDTH-1:0]              program_count_out,
   output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
   output logic                               writeback_enabled_out,
   output logic [DATA_WIDTH-1:0]              writeback_data_out,
   output logic                               writeback_data_valid_out,
   output logic                               access_fault_out
);

   memory_state_t                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]              pc_q, pc_d;
   logic                               load_q, load_d;
   logic                               store_q, store_d;
   logic [2:0]                         funct3_q, funct3_d;
   logic [REGISTER_INDEXING_WIDTH-1:0] rd_q, rd_d;
   logic                               wb_en_q, wb_en_d;
   logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
   logic [DATA_WIDTH-1:0]              store_data_q, store_data_d;
   logic [DATA_WIDTH-1:0]              wb_data_q, wb_data_d;
   logic                               wb_vld_q, wb_vld_d;
   logic                               fault_q, fault_d;

   logic                  transfer_prev;
   logic                  transfer_next;
   logic                  mem_op_in;
   logic                  misaligned_in;
   logic                  fault_in;
   logic [DATA_WIDTH-1:0] load_value;
   logic                  unused_ok;

   // Store data validity is implied by the execute stage handing over a store.
   assign unused_ok = memory_store_data_valid_in;

   assign transfer_prev = prev_done && !stall_prev;
   assign transfer_next = done_next && !next_stall;
   assign done_next     = (state_q == DONE);
   assign stall_prev    = rst || ((state_q != EMPTY) && !((state_q == DONE) && transfer_next));

   assign mem_op_in = load_in || store_in;

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
   // Halfwords need a[0]==0, words need a[1:0]==0; illegal widths are faulted separately.
   assign misaligned_in = ((funct_3_in[1:0] == 2'd1) && result_data_in[0]) ||
                          ((funct_3_in[1:0] == 2'd2) && (result_data_in[1:0] != 2'b00));
`else
   // Misaligned offsets are truncated by the lane logic instead of trapping.
   assign misaligned_in = 1'b0;
`endif

   assign fault_in = mem_op_in && (!funct3_legal(load_in, funct_3_in) || misaligned_in);

   load_align u_load_align (
      .funct3 (funct3_q),
      .offset (addr_q[1:0]),
      .word   (mem_response_data),
      .value  (load_value)
   );

   // Next-state and capture logic: advance the bus FSM, then take a new instruction if one transfers in.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      load_d       = load_q;
      store_d      = store_q;
      funct3_d     = funct3_q;
      rd_d         = rd_q;
      wb_en_d      = wb_en_q;
      addr_d       = addr_q;
      store_data_d = store_data_q;
      wb_data_d    = wb_data_q;
      wb_vld_d     = wb_vld_q;
      fault_d      = fault_q;
      case (state_q)
         REQUEST: begin
            if (mem_request_ready) state_d = RESPONSE;
         end
         RESPONSE: begin
            if (mem_response_valid) begin
               state_d = DONE;
               if (load_q) begin
                  wb_data_d = load_value;
                  wb_vld_d  = 1'b1;
               end
            end
         end
         DONE: begin
            if (transfer_next) begin
               state_d = EMPTY;
               fault_d = 1'b0;
            end
         end
         default: ;
      endcase
      if (transfer_prev) begin
         pc_d         = program_count_in;
         load_d       = load_in;
         store_d      = store_in && !load_in;
         funct3_d     = funct_3_in;
         rd_d         = write_register_in;
         wb_en_d      = writeback_enabled_in;
         addr_d       = result_data_in;
         store_data_d = memory_store_data_in;
         wb_data_d    = result_data_in;
         wb_vld_d     = mem_op_in ? 1'b0 : result_data_valid_in;
         fault_d      = fault_in;
         state_d      = (mem_op_in && !fault_in) ? REQUEST : DONE;
      end
   end

   // State and captured instruction registers; reset empties the stage and drops any bus request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         pc_q         <= '0;
         load_q       <= 1'b0;
         store_q      <= 1'b0;
         funct3_q     <= '0;
         rd_q         <= '0;
         wb_en_q      <= 1'b0;
         addr_q       <= '0;
         store_data_q <= '0;
         wb_data_q    <= '0;
         wb_vld_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         load_q       <= load_d;
         store_q      <= store_d;
         funct3_q     <= funct3_d;
         rd_q         <= rd_d;
         wb_en_q      <= wb_en_d;
         addr_q       <= addr_d;
         store_data_q <= store_data_d;
         wb_data_q    <= wb_data_d;
         wb_vld_q     <= wb_vld_d;
         fault_q      <= fault_d;
      end
   end

   // Store lane formatting: strobes follow the truncated offset, data is replicated across lanes.
   always_comb begin
      mem_byte_enable = '0;
      mem_write_data  = store_data_q;
      case (funct3_q)
         SB: begin
            mem_byte_enable = 4'b0001 << addr_q[1:0];
            mem_write_data  = {4{store_data_q[7:0]}};
         end
         SH: begin
            mem_byte_enable = 4'b0011 << {addr_q[1], 1'b0};
            mem_write_data  = {2{store_data_q[15:0]}};
         end
         SW: mem_byte_enable = 4'hF;
         default: ;
      endcase
   end

   assign mem_request_valid = (state_q == REQUEST);
   assign mem_address       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_write         = store_q;

   assign instruction_writeback_register = rd_q;
   assign instruction_writeback_enabled  = wb_en_q && (state_q != EMPTY);
   assign program_count_out              = pc_q;
   assign write_register_out             = rd_q;
   assign writeback_enabled_out          = wb_en_q;
   assign writeback_data_out             = wb_data_q;
   assign writeback_data_valid_out       = wb_vld_q;
   assign access_fault_out               = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized ops against a transaction-level model.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_prev, prev_done, next_stall, done_next;
   logic [4:0]  instruction_writeback_register;
   logic        instruction_writeback_enabled;
   logic [31:0] program_count_in;
   logic        load_in, store_in;
   logic [2:0]  funct_3_in;
   logic [4:0]  write_register_in;
   logic        writeback_enabled_in;
   logic [31:0] result_data_in;
   logic        result_data_valid_in;
   logic [31:0] memory_store_data_in;
   logic        memory_store_data_valid_in;
   logic        mem_request_valid, mem_request_ready;
   logic [31:0] mem_address;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_write_data;
   logic        mem_response_valid;
   logic [31:0] mem_response_data;
   logic [31:0] program_count_out;
   logic [4:0]  write_register_out;
   logic        writeback_enabled_out;
   logic [31:0] writeback_data_out;
   logic        writeback_data_valid_out;
   logic        access_fault_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memory_stage dut (
      .clk                            (clk),
      .rst                            (rst),
      .stall_prev                     (stall_prev),
      .prev_done                      (prev_done),
      .next_stall                     (next_stall),
      .done_next                      (done_next),
      .instruction_writeback_register (instruction_writeback_register),
      .instruction_writeback_enabled  (instruction_writeback_enabled),
      .program_count_in               (program_count_in),
      .load_in                        (load_in),
      .store_in                       (store_in),
      .funct_3_in                     (funct_3_in),
      .write_register_in              (write_register_in),
      .writeback_enabled_in           (writeback_enabled_in),
      .result_data_in                 (result_data_in),
      .result_data_valid_in           (result_data_valid_in),
      .memory_store_data_in           (memory_store_data_in),
      .memory_store_data_valid_in     (memory_store_data_valid_in),
      .mem_request_valid              (mem_request_valid),
      .mem_request_ready              (mem_request_ready),
      .mem_address                    (mem_address),
      .mem_write                      (mem_write),
      .mem_byte_enable                (mem_byte_enable),
      .mem_write_data                 (mem_write_data),
      .mem_response_valid             (mem_response_valid),
      .mem_response_data              (mem_response_data),
      .program_count_out              (program_count_out),
      .write_register_out             (write_register_out),
      .writeback_enabled_out          (writeback_enabled_out),
      .writeback_data_out             (writeback_data_out),
      .writeback_data_valid_out       (writeback_data_valid_out),
      .access_fault_out               (access_fault_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int access_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_fault(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit f;
      if (!ld && !st) return 1'b0;
      f = ld ? (f3 == 3 || f3 >= 6) : (f3 >= 3);
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
      if (!f && (a % access_size(f3)) != 0) f = 1'b1;
`endif
      return f;
   endfunction

   function automatic int model_offset(input logic [2:0] f3, input logic [31:0] a);
      int lo;
      lo = int'(a % 4);
      return lo - (lo % access_size(f3));
   endfunction

   function automatic logic [3:0] model_strobe(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] s;
      s = ((32'd1 << access_size(f3)) - 1) << model_offset(f3, a);
      return s[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (access_size(f3))
         1:       return (d & 32'hFF) * 32'h0101_0101;
         2:       return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] v, mask;
      int sz;
      sz = access_size(f3);
      v  = w >> (8 * model_offset(f3, a));
      if (sz < 4) begin
         mask = (32'd1 << (8 * sz)) - 1;
         v    = v & mask;
         if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic present(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] res,
                          input logic [31:0] sd, input bit rv, input logic [4:0] rd,
                          input logic [31:0] pc, input bit wbe);
      load_in                    = ld;
      store_in                   = st;
      funct_3_in                 = f3;
      result_data_in             = res;
      memory_store_data_in       = sd;
      memory_store_data_valid_in = st;
      result_data_valid_in       = rv;
      write_register_in          = rd;
      program_count_in           = pc;
      writeback_enabled_in       = wbe;
   endtask

   // One instruction end to end: accept, serve the bus as memory, check results, drain with optional hold.
   task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] sd, input bit rv, input logic [31:0] rdata,
                        input int rdly, input int rsdly, input int hold);
      logic [4:0]  rd;
      logic [31:0] pc;
      bit          wbe, flt, mem_ok, want_vld;
      logic [31:0] want_data;
      rd       = 5'($urandom);
      pc       = $urandom & 32'hFFFF_FFFC;
      wbe      = 1'($urandom);
      flt      = model_fault(ld, st, f3, res);
      mem_ok   = (ld || st) && !flt;
      want_vld = (ld && !flt) ? 1'b1 : ((st || flt) ? 1'b0 : rv);
      want_data = ld ? model_load(f3, res, rdata) : res;

      present(ld, st, f3, res, sd, rv, rd, pc, wbe);
      prev_done = 1'b1;
      #1;
      check_eq("stall_prev_idle", 32'(stall_prev), 32'd0);
      @(posedge clk); #1;
      prev_done = 1'b0;
      present(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 1'b0, 5'd0, 32'd0, 1'b0);
      if (mem_ok) begin
         check_eq("req_valid", 32'(mem_request_valid), 32'd1);
         check_eq("req_addr", mem_address, res & 32'hFFFF_FFFC);
         check_eq("req_write", 32'(mem_write), 32'(st));
         check_eq("hazard_en", 32'(instruction_writeback_enabled), 32'(wbe));
         if (st) begin
            check_eq("req_strobe", 32'(mem_byte_enable), 32'(model_strobe(f3, res)));
            check_eq("req_wdata", mem_write_data, model_wdata(f3, sd));
         end
         for (int i = 0; i < rdly; i++) begin
            @(posedge clk); #1;
            check_eq("req_held", 32'(mem_request_valid), 32'd1);
            check_eq("req_addr_held", mem_address, res & 32'hFFFF_FFFC);
            check_eq("stall_prev_req", 32'(stall_prev), 32'd1);
         end
         mem_request_ready = 1'b1;
         @(posedge clk); #1;
         mem_request_ready = 1'b0;
         check_eq("req_dropped", 32'(mem_request_valid), 32'd0);
         for (int i = 0; i < rsdly; i++) begin
            check_eq("done_wait_resp", 32'(done_next), 32'd0);
            @(posedge clk); #1;
         end
         mem_response_valid = 1'b1;
         mem_response_data  = rdata;
         @(posedge clk); #1;
         mem_response_valid = 1'b0;
         mem_response_data  = $urandom;
      end else begin
         check_eq("no_request", 32'(mem_request_valid), 32'd0);
      end
      check_eq("done_next", 32'(done_next), 32'd1);
      check_eq("fault", 32'(access_fault_out), 32'(flt));
      check_eq("wb_valid", 32'(writeback_data_valid_out), 32'(want_vld));
      if (want_vld || (!ld && !st)) check_eq("wb_data", writeback_data_out, want_data);
      check_eq("pc_out", program_count_out, pc);
      check_eq("rd_out", 32'(write_register_out), 32'(rd));
      check_eq("wben_out", 32'(writeback_enabled_out), 32'(wbe));
      next_stall = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq("done_held", 32'(done_next), 32'd1);
         check_eq("stall_prev_hold", 32'(stall_prev), 32'd1);
         if (want_vld || (!ld && !st)) check_eq("wb_data_held", writeback_data_out, want_data);
      end
      next_stall = 1'b0;
      #1;
      check_eq("stall_prev_drain", 32'(stall_prev), 32'd0);
      @(posedge clk); #1;
      check_eq("drained", 32'(done_next), 32'd0);
      check_eq("hazard_en_empty", 32'(instruction_writeback_enabled), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ld, st;
      int          kind;
      logic [31:0] a;

      rst                = 1'b1;
      prev_done          = 1'b0;
      next_stall         = 1'b0;
      mem_request_ready  = 1'b0;
      mem_response_valid = 1'b0;
      mem_response_data  = '0;
      present(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      check_eq("rst_stall_prev", 32'(stall_prev), 32'd1);
      check_eq("rst_done_next", 32'(done_next), 32'd0);
      check_eq("rst_req_valid", 32'(mem_request_valid), 32'd0);
      check_eq("rst_fault", 32'(access_fault_out), 32'd0);
      check_eq("rst_hazard_en", 32'(instruction_writeback_enabled), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      do_op(0, 0, 3'd0, 32'h1234, 32'h0, 1, 32'h0, 0, 0, 0);          // ADD pass-through
      do_op(1, 0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF_0000, 0, 0, 0);   // LB -> 0xFFFFFF80
      do_op(1, 0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF_0000, 0, 1, 0);   // LBU -> 0x00000080
      do_op(0, 1, 3'd1, 32'h102, 32'hABCD, 0, 32'h0, 0, 0, 0);        // SH lanes 3:2
      do_op(1, 0, 3'd2, 32'h200, 32'h0, 0, 32'hDEAD_BEEF, 5, 2, 3);   // ready low 5, hold 3
      do_op(1, 0, 3'd2, 32'h101, 32'h0, 0, 32'h1357_9BDF, 0, 0, 0);   // LW misaligned
      do_op(1, 0, 3'd3, 32'h100, 32'h0, 0, 32'h0, 0, 0, 0);           // illegal load funct3
      do_op(0, 1, 3'd5, 32'h100, 32'h55, 0, 32'h0, 0, 0, 0);          // illegal store funct3

      // Back-to-back ALU ops at one per cycle
      present(0, 0, 3'd0, 32'h11, 32'h0, 1, 5'd3, 32'h40, 1);
      prev_done = 1'b1;
      @(posedge clk); #1;
      check_eq("b2b_done1", 32'(done_next), 32'd1);
      check_eq("b2b_data1", writeback_data_out, 32'h11);
      present(0, 0, 3'd0, 32'h22, 32'h0, 1, 5'd4, 32'h44, 1);
      #1;
      check_eq("b2b_accept", 32'(stall_prev), 32'd0);
      @(posedge clk); #1;
      prev_done = 1'b0;
      check_eq("b2b_done2", 32'(done_next), 32'd1);
      check_eq("b2b_data2", writeback_data_out, 32'h22);
      check_eq("b2b_pc2", program_count_out, 32'h44);
      @(posedge clk); #1;
      check_eq("b2b_drained", 32'(done_next), 32'd0);

      // Randomized mix
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 2);
         ld   = (kind == 1);
         st   = (kind == 2);
         a    = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         do_op(ld, st, 3'($urandom_range(0, 7)), a, $urandom, 1'($urandom), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // Reset while waiting for a response; the late response must be discarded
      present(1, 0, 3'd2, 32'h300, 32'h0, 0, 5'd7, 32'h80, 1);
      prev_done = 1'b1;
      #1;
      @(posedge clk); #1;
      prev_done = 1'b0;
      check_eq("rr_req", 32'(mem_request_valid), 32'd1);
      mem_request_ready = 1'b1;
      @(posedge clk); #1;
      mem_request_ready = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("rr_req_dropped", 32'(mem_request_valid), 32'd0);
      check_eq("rr_stall_prev", 32'(stall_prev), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      mem_response_valid = 1'b1;
      mem_response_data  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      mem_response_valid = 1'b0;
      check_eq("rr_no_done", 32'(done_next), 32'd0);
      check_eq("rr_empty", 32'(stall_prev), 32'd0);
      check_eq("rr_hazard_en", 32'(instruction_writeback_enabled), 32'd0);
      @(posedge clk); #1;
      check_eq("rr_still_empty", 32'(done_next), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
